bpu: RTL
========

// Module: bpu
// PURPOSE
//   Branch prediction unit at the fetch end of the branch-resolution path: a direct-mapped BTB
//   with per-entry 2-bit saturating counters. Fetch looks up the PC and gets a registered
//   taken/target prediction. Execute writes back each resolved control-transfer outcome
//   (taken flag + taken PC, as produced by the bru) to train the tables.
// PARAMETERS
//   ENTRIES  64  BTB/counter entries; power of two, >= 2; IDX_W = $clog2(ENTRIES)
//   TAG_W    10  tag bits stored per entry; tag = pc[IDX_W+2+TAG_W-1 : IDX_W+2]
//   (XLEN comes from rei_pkg; index = pc[IDX_W+1:2])
// PORTS
//   clk_i        in   1     clock
//   rst_i        in   1     synchronous reset, active-high
//   f_vld_i      in   1     fetch lookup request valid
//   f_pc_i       in   XLEN  fetch PC to predict
//   p_vld_o      out  1     prediction valid (f_vld_i delayed 1 cycle)
//   p_tkn_o      out  1     predicted taken
//   p_tgt_o      out  XLEN  predicted next PC (target if taken, else looked-up PC + 4)
//   u_vld_i      in   1     resolved control-transfer update valid
//   u_pc_i       in   XLEN  PC of the resolved instruction
//   u_is_cond_i  in   1     1 = conditional branch; 0 = jal/jalr
//   u_tkn_i      in   1     resolved taken
//   u_tkn_pc_i   in   XLEN  resolved taken target
//   rdy_o        out  1     1 = init sweep done; predictions/updates active
// BEHAVIOUR
//   - Reset: p_vld_o=0, p_tkn_o=0, p_tgt_o=0, rdy_o=0; FSM -> INIT, sweep counter=0.
//   - FSM INIT: 1 entry per cycle: valid=0, ctr=2'b01. Sweep counter runs 0..ENTRIES-1.
//     After writing entry ENTRIES-1: -> RUN and rdy_o=1 next cycle (ENTRIES cycles after reset release).
//     In INIT, updates are ignored. Lookups still produce p_vld_o, with p_tkn_o=0 and p_tgt_o=pc+4.
//   - FSM RUN: stays in RUN until rst_i. rst_i at any time (including mid-sweep) restarts INIT from entry 0.
//   - Lookup latency: exactly 1 cycle; all p_* outputs are registered.
//     p_vld_o(t+1) = f_vld_i(t).
//     hit = valid[idx] && tag[idx]==f_pc tag.
//     p_tkn_o = hit && (!cond[idx] || ctr[idx][1]).
//     p_tgt_o = p_tkn_o ? tgt[idx] : f_pc_i + 4 (mod 2^XLEN).
//     When f_vld_i=0: p_tkn_o=0, p_tgt_o=0.
//   - Update, in RUN when u_vld_i=1. uhit = valid && tag match at u_pc_i index.
//     jal/jalr (u_is_cond_i=0): write valid=1, tag, tgt=u_tkn_pc_i, cond=0, ctr=2'b11.
//     cond & taken, uhit: ctr = sat_inc(ctr) (11 stays 11); tgt=u_tkn_pc_i; cond=1.
//     cond & taken, !uhit: allocate (replace) with valid=1, tag, tgt, cond=1, ctr=2'b10.
//     cond & not taken, uhit: ctr = sat_dec(ctr) (00 stays 00); entry stays valid.
//     cond & not taken, !uhit: no state change.
//   - Simultaneous lookup and update to the same index in cycle t: the lookup uses
//     pre-update contents; the update is visible to lookups from cycle t+1.
//   - u_tkn_pc_i is stored as-is (bit 0 already cleared for jalr). PC bits [1:0] are ignored for index/tag.
// TESTING
//   1. rst_i 1 cycle, ENTRIES=64 -> rdy_o=0 for 64 cycles then 1. A lookup at 0x100 during INIT -> p_tkn_o=0, p_tgt_o=0x104.
//   2. Update cond taken pc=0x200 tgt=0x180 -> lookup 0x200 gives p_tkn_o=1, p_tgt_o=0x180 one cycle later.
//   3. Same entry: 2 not-taken updates (10->01->00) -> p_tkn_o=0, p_tgt_o=0x204.
//      Then 3 taken updates -> ctr=11. A 4th taken update keeps ctr=11 (saturation).
//   4. jal pc=0x300 tgt=0x40 -> lookup 0x300 gives taken, p_tgt_o=0x40.
//      Then update cond pc=0x300+(ENTRIES*4) taken -> replaces the entry; lookup 0x300 now misses (p_tgt_o=0x304).
//   5. Same cycle: lookup 0x200 and taken update pc=0x200 tgt=0x500 on a cold entry -> lookup predicts
//      not taken; a repeat lookup the next cycle predicts 0x500.
//   6. Assert rst_i mid-sweep (cycle 20) and again after RUN with entries trained -> rdy_o=0 for 64 cycles;
//      all prior entries miss afterwards; outputs return to 0.

Source files
------------

// File: rtl/bpu.sv
// Branch prediction unit: direct-mapped BTB with per-entry 2-bit saturating counters,
// registered one-cycle lookup, training from resolved control transfers.
package rei_pkg;
  parameter int XLEN = 32;
endpackage

module bpu
  import rei_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            f_vld_i,
  input  logic [XLEN-1:0] f_pc_i,
  output logic            p_vld_o,
  output logic            p_tkn_o,
  output logic [XLEN-1:0] p_tgt_o,
  input  logic            u_vld_i,
  input  logic [XLEN-1:0] u_pc_i,
  input  logic            u_is_cond_i,
  input  logic            u_tkn_i,
  input  logic [XLEN-1:0] u_tkn_pc_i,
  output logic            rdy_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TLO   = IDX_W + 2;

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic             val_q  [ENTRIES];
  logic             cond_q [ENTRIES];
  logic [1:0]       ctr_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q  [ENTRIES];
  logic [XLEN-1:0]  tgt_q  [ENTRIES];

  logic             p_vld_q, p_vld_d, p_tkn_q, p_tkn_d;
  logic [XLEN-1:0]  p_tgt_q, p_tgt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lookup reads the arrays before this cycle's update lands.
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit, f_tkn;

  assign f_idx = f_pc_i[IDX_W+1:2];
  assign f_tag = f_pc_i[TLO+TAG_W-1:TLO];
  assign f_hit = (state_q == RUN) && val_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_tkn = f_hit && (!cond_q[f_idx] || ctr_q[f_idx][1]);

  always_comb begin
    p_vld_d = f_vld_i;
    p_tkn_d = f_vld_i && f_tkn;
    p_tgt_d = '0;
    if (f_vld_i) p_tgt_d = f_tkn ? tgt_q[f_idx] : f_pc_i + XLEN'(4);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_vld_q <= 1'b0;
      p_tkn_q <= 1'b0;
      p_tgt_q <= '0;
    end else begin
      p_vld_q <= p_vld_d;
      p_tkn_q <= p_tkn_d;
      p_tgt_q <= p_tgt_d;
    end
  end

  // Training: compute the full replacement entry for the update index.
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit, wr_en, wr_cond;
  logic [1:0]       wr_ctr, u_ctr;
  logic [XLEN-1:0]  wr_tgt;

  assign u_idx = u_pc_i[IDX_W+1:2];
  assign u_tag = u_pc_i[TLO+TAG_W-1:TLO];
  assign u_hit = val_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_ctr = ctr_q[u_idx];

  always_comb begin
    wr_en   = 1'b0;
    wr_cond = 1'b1;
    wr_ctr  = u_ctr;
    wr_tgt  = u_tkn_pc_i;
    if (u_vld_i && state_q == RUN && !rst_i) begin
      if (!u_is_cond_i) begin
        wr_en   = 1'b1;
        wr_cond = 1'b0;
        wr_ctr  = 2'b11;
      end else if (u_tkn_i) begin
        wr_en  = 1'b1;
        wr_ctr = !u_hit ? 2'b10 : (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1;
      end else if (u_hit) begin
        wr_en   = 1'b1;
        wr_cond = cond_q[u_idx];
        wr_tgt  = tgt_q[u_idx];
        wr_ctr  = (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == INIT && !rst_i) begin
      val_q[cnt_q] <= 1'b0;
      ctr_q[cnt_q] <= 2'b01;
    end else if (wr_en) begin
      val_q[u_idx]  <= 1'b1;
      tag_q[u_idx]  <= u_tag;
      tgt_q[u_idx]  <= wr_tgt;
      cond_q[u_idx] <= wr_cond;
      ctr_q[u_idx]  <= wr_ctr;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{u_pc_i[1:0], u_pc_i[XLEN-1:TLO+TAG_W]};

  assign p_vld_o = p_vld_q;
  assign p_tkn_o = p_tkn_q;
  assign p_tgt_o = p_tgt_q;
  assign rdy_o   = (state_q == RUN);
endmodule
